// File: rtl/maquina_estados_param.sv
// Link power-state controller: watches FIFO empty flags, reports IDLE/ACTIVE/ERROR, latches FIFO thresholds.
// Optional active-cycle counter enabled by defining MAQ_ACT_CNT_EN.
//
// state  | meaning
// RESET  | post-reset, moves to INIT on the next edge
// INIT   | capturing thresholds while init is held
// IDLE   | all FIFOs empty, link may sleep
// ACTIVE | traffic present, counting empty cycles before idling
// ERROR  | captured low threshold above high threshold, waits for init
module maquina_estados_param #(
  parameter int N_CH      = 4,
  parameter int UMB_W     = 3,
  parameter int IDLE_DLY  = 4,
  parameter int ACT_CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [UMB_W-1:0] umbral_in_L,
  input  logic [UMB_W-1:0] umbral_in_H,
  input  logic [N_CH-1:0]  emp_in,
  input  logic [N_CH-1:0]  emp_out,
  output logic             idle_out,
  output logic             active_out,
  output logic             error_out,
  output logic [UMB_W-1:0] umbral_out_L,
  output logic [UMB_W-1:0] umbral_out_H,
`ifdef MAQ_ACT_CNT_EN
  output logic [ACT_CNT_W-1:0] act_cycles,
`endif
  output logic [2:0]       state_out
);

  localparam int CNT_W = $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

  if (IDLE_DLY < 1) begin : g_bad_dly
    $error("IDLE_DLY must be at least 1");
  end
  if (ACT_CNT_W < 1) begin : g_bad_act_w
    $error("ACT_CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
  logic [UMB_W-1:0] umb_l_q, umb_h_q;
  logic             all_empty;

  assign all_empty = (&emp_in) & (&emp_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RESET;
      idle_cnt <= '0;
      umb_l_q  <= '0;
      umb_h_q  <= '0;
    end else begin
      state    <= state_nx;
      idle_cnt <= idle_cnt_nx;
      if (state == ST_INIT) begin
        umb_l_q <= umbral_in_L;
        umb_h_q <= umbral_in_H;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    idle_cnt_nx = '0;
    case (state)
      ST_RESET: state_nx = ST_INIT;
      ST_INIT: begin
        if (!init) state_nx = (umbral_in_L > umbral_in_H) ? ST_ERROR : ST_IDLE;
      end
      ST_IDLE: begin
        if (!all_empty) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (all_empty) begin
          if (idle_cnt == CNT_LAST) state_nx = ST_IDLE;
          else idle_cnt_nx = idle_cnt + 1'b1;
        end
      end
      ST_ERROR: state_nx = ST_ERROR;
      default:  state_nx = ST_RESET;
    endcase
    // init overrides everything except the mandatory RESET -> INIT step
    if (init && (state != ST_RESET)) begin
      state_nx    = ST_INIT;
      idle_cnt_nx = '0;
    end
  end

`ifdef MAQ_ACT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_cycles <= '0;
    end else if (state == ST_INIT) begin
      act_cycles <= '0;
    end else if ((state == ST_ACTIVE) && !(&act_cycles)) begin
      act_cycles <= act_cycles + 1'b1;
    end
  end
`endif

  assign idle_out     = (state == ST_IDLE);
  assign active_out   = (state == ST_ACTIVE);
  assign error_out    = (state == ST_ERROR);
  assign umbral_out_L = (state == ST_ERROR) ? '0 : umb_l_q;
  assign umbral_out_H = (state == ST_ERROR) ? '0 : umb_h_q;
  assign state_out    = state;

endmodule

// File: tb/tb_maquina_estados_param.sv
// Directed bench for maquina_estados_param with hand-computed expectations.
// Act-counter checks compile in only when MAQ_ACT_CNT_EN is defined.
module tb_maquina_estados_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] umbral_in_L, umbral_in_H;
  logic [3:0] emp_in, emp_out;
  logic       idle_out, active_out, error_out;
  logic [2:0] umbral_out_L, umbral_out_H;
  logic [2:0] state_out;
`ifdef MAQ_ACT_CNT_EN
  logic [1:0] act_cycles;
`endif

  int checks = 0;
  int failures = 0;

  maquina_estados_param #(
    .N_CH(4), .UMB_W(3), .IDLE_DLY(4), .ACT_CNT_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .umbral_in_L(umbral_in_L),
    .umbral_in_H(umbral_in_H),
    .emp_in(emp_in),
    .emp_out(emp_out),
    .idle_out(idle_out),
    .active_out(active_out),
    .error_out(error_out),
    .umbral_out_L(umbral_out_L),
    .umbral_out_H(umbral_out_H),
`ifdef MAQ_ACT_CNT_EN
    .act_cycles(act_cycles),
`endif
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] st,
                              input logic idl, input logic act, input logic err);
    check_val({tag, "_state"},  32'(state_out),  32'(st));
    check_val({tag, "_idle"},   32'(idle_out),   32'(idl));
    check_val({tag, "_active"}, 32'(active_out), 32'(act));
    check_val({tag, "_error"},  32'(error_out),  32'(err));
  endtask

  task automatic check_umb(input string tag, input logic [2:0] l, input logic [2:0] h);
    check_val({tag, "_umbL"}, 32'(umbral_out_L), 32'(l));
    check_val({tag, "_umbH"}, 32'(umbral_out_H), 32'(h));
  endtask

  initial begin
    reset = 1'b1; init = 1'b0;
    umbral_in_L = 3'd0; umbral_in_H = 3'd0;
    emp_in = 4'hF; emp_out = 4'hF;
    #2;
    check_status("rst0", 3'd0, 1'b0, 1'b0, 1'b0);
    check_umb("rst0", 3'd0, 3'd0);

    // capture thresholds 2/5
    reset = 1'b0; init = 1'b1; umbral_in_L = 3'd2; umbral_in_H = 3'd5;
    tick(1);
    check_status("init1", 3'd1, 1'b0, 1'b0, 1'b0);
    check_umb("init1", 3'd0, 3'd0);
    tick(1);
    check_umb("init2", 3'd2, 3'd5);
    tick(1);
    check_status("init3", 3'd1, 1'b0, 1'b0, 1'b0);
    init = 1'b0;
    tick(1);
    check_status("idle1", 3'd2, 1'b1, 1'b0, 1'b0);
    check_umb("idle1", 3'd2, 3'd5);

    // one non-empty cycle, then exactly IDLE_DLY empty cycles back to IDLE
    emp_in = 4'b1101;
    tick(1);
    check_status("act1", 3'd3, 1'b0, 1'b1, 1'b0);
    emp_in = 4'hF;
    tick(3);
    check_status("act1_hold", 3'd3, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_status("idle2", 3'd2, 1'b1, 1'b0, 1'b0);
`ifdef MAQ_ACT_CNT_EN
    check_val("act_hold_idle", 32'(act_cycles), 32'd3);
`endif

    // hysteresis restart on a single non-empty cycle
    emp_in = 4'b1110;
    tick(1);
    emp_in = 4'hF;
    tick(3);
    check_status("act2_c3", 3'd3, 1'b0, 1'b1, 1'b0);
    emp_out = 4'b1011;
    tick(1);
    check_status("act2_brk", 3'd3, 1'b0, 1'b1, 1'b0);
    emp_out = 4'hF;
    tick(3);
    check_status("act2_c3b", 3'd3, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_status("idle3", 3'd2, 1'b1, 1'b0, 1'b0);

    // bad thresholds -> ERROR
    init = 1'b1; umbral_in_L = 3'd6; umbral_in_H = 3'd2;
    tick(1);
    check_status("init_e", 3'd1, 1'b0, 1'b0, 1'b0);
    check_umb("init_e", 3'd2, 3'd5);
    init = 1'b0;
    tick(1);
    check_status("err1", 3'd4, 1'b0, 1'b0, 1'b1);
    check_umb("err1", 3'd0, 3'd0);
    emp_in = 4'h0;
    tick(2);
    check_status("err_hold", 3'd4, 1'b0, 1'b0, 1'b1);
    emp_in = 4'hF;
    init = 1'b1; umbral_in_L = 3'd1; umbral_in_H = 3'd3;
    tick(1);
    check_status("init_r", 3'd1, 1'b0, 1'b0, 1'b0);
    check_umb("init_r", 3'd6, 3'd2);
    init = 1'b0;
    tick(1);
    check_status("idle4", 3'd2, 1'b1, 1'b0, 1'b0);
    check_umb("idle4", 3'd1, 3'd3);

    // thresholds frozen outside INIT
    umbral_in_L = 3'd7; umbral_in_H = 3'd7;
    tick(2);
    check_umb("frozen", 3'd1, 3'd3);
`ifdef MAQ_ACT_CNT_EN
    check_val("act_clr", 32'(act_cycles), 32'd0);
`endif

    // long ACTIVE stretch, act counter saturates
    emp_in = 4'h0;
    tick(1);
    check_status("act3", 3'd3, 1'b0, 1'b1, 1'b0);
    tick(2);
`ifdef MAQ_ACT_CNT_EN
    check_val("act_cnt2", 32'(act_cycles), 32'd2);
`endif
    tick(4);
`ifdef MAQ_ACT_CNT_EN
    check_val("act_sat", 32'(act_cycles), 32'd3);
`endif
    check_status("act3_hold", 3'd3, 1'b0, 1'b1, 1'b0);

    // async reset mid-ACTIVE
    #3;
    reset = 1'b1;
    #1;
    check_status("arst", 3'd0, 1'b0, 1'b0, 1'b0);
    check_umb("arst", 3'd0, 3'd0);
`ifdef MAQ_ACT_CNT_EN
    check_val("arst_act", 32'(act_cycles), 32'd0);
`endif
    tick(1);
    check_status("arst_edge", 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; emp_in = 4'hF;
    tick(1);
    check_status("post_init", 3'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_status("post_idle", 3'd2, 1'b1, 1'b0, 1'b0);
    check_umb("post_idle", 3'd7, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
